// File: rtl/cnn_kernel_fetcher_pkg.sv
// Shared widths, payload types and FSM encoding for the CNN parameter-memory kernel fetcher.
// Optional checksum support is selected with FETCH_CHECKSUM_EN.
package cnn_mem_pkg;
    localparam int WORD_W    = 16;
    localparam int KWORDS    = 25;
    localparam int MEM_WORDS = 50704;

    typedef logic [WORD_W-1:0]        word_t;
    typedef logic [KWORDS*WORD_W-1:0] kernel_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_WAIT,
        S_HOLD,
        S_FIN
    } state_t;
endpackage

// File: rtl/cnn_kernel_fetcher_if.sv
// Kernel stream from the fetcher to the convolution engine (valid/ready).
interface cnn_kernel_fetcher_if;
    import cnn_mem_pkg::*;

    kernel_t     k_data;
    logic        k_valid;
    logic        k_ready;
    logic [15:0] k_index;
    logic        k_last;

    modport master (output k_data, k_valid, k_index, k_last, input k_ready);
    modport slave  (input k_data, k_valid, k_index, k_last, output k_ready);
endinterface

// File: rtl/cnn_kernel_fetcher_kernel_out_reg.sv
// One-entry output holding register: keeps the kernel stable under backpressure.
// With FETCH_CHECKSUM_EN it also sums every accepted kernel's words (mod 2^16).
module kernel_out_reg
    import cnn_mem_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_load,
    input  logic                 i_clear,
    input  kernel_t              i_data,
    input  logic [15:0]          i_index,
    input  logic                 i_last,
    output logic                 o_accept,
    cnn_kernel_fetcher_if.master k_if
`ifdef FETCH_CHECKSUM_EN
    ,
    output word_t                o_csum
`endif
);
    kernel_t     r_data;
    logic        r_valid;
    logic [15:0] r_index;
    logic        r_last;

    assign o_accept = r_valid & k_if.k_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_index <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
            r_index <= i_index;
            r_last  <= i_last;
        end else if (o_accept) begin
            r_valid <= 1'b0;
        end
    end

    assign k_if.k_data  = r_data;
    assign k_if.k_valid = r_valid;
    assign k_if.k_index = r_index;
    assign k_if.k_last  = r_last;

`ifdef FETCH_CHECKSUM_EN
    word_t w_ksum;
    word_t r_csum;

    always_comb begin
        w_ksum = '0;
        for (int j = 0; j < KWORDS; j++) begin
            w_ksum = w_ksum + r_data[j*WORD_W +: WORD_W];
        end
    end

    // A start cannot coincide with a handshake, so clear simply wins.
    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_csum <= '0;
        end else if (o_accept) begin
            r_csum <= r_csum + w_ksum;
        end
    end

    assign o_csum = r_csum;
`endif
endmodule

// File: rtl/cnn_kernel_fetcher.sv
// Reads NUM 25-word kernels from CNN parameter memory and streams them to the conv engine.
// Define FETCH_CHECKSUM_EN to add the csum output for loader verification.
module cnn_kernel_fetcher
    import cnn_mem_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [15:0]          num_kernels,
    output logic [ADDR_W-1:0]    mem_address,
    output logic                 mem_write_enable,
    input  kernel_t              mem_data_out,
    cnn_kernel_fetcher_if.master k_if,
    output logic                 busy,
    output logic                 done,
    output logic                 addr_err
`ifdef FETCH_CHECKSUM_EN
    ,
    output word_t                csum
`endif
);
    // state   | meaning
    // IDLE    | waiting for start
    // CHECK   | range-check the requested kernel span
    // ISSUE   | present cur_addr to memory
    // WAIT    | count RD_LAT cycles of read latency
    // HOLD    | kernel presented, waiting for handshake
    // FIN     | one-cycle done pulse

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_base;
    logic [15:0]       r_num;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [15:0]       r_idx;
    logic [1:0]        r_wait_cnt;
    logic              r_addr_err;
    logic [32:0]       w_end;
    logic              w_range_err;
    logic              w_load;
    logic              w_last;
    logic              w_accept;
    logic              w_start_acc;

    assign w_end       = 33'(r_base) + 33'(r_num) * 33'(KWORDS) - 33'd1;
    assign w_range_err = w_end > 33'(MEM_WORDS - 1);
    assign w_start_acc = (r_state == S_IDLE) && start;
    assign w_load      = (r_state == S_WAIT) && (r_wait_cnt == 2'd0);
    assign w_last      = (r_idx == r_num - 16'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_CHECK;
            S_CHECK: begin
                if (r_num == 16'd0 || w_range_err) w_state_nxt = S_FIN;
                else                               w_state_nxt = S_ISSUE;
            end
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT:  if (r_wait_cnt == 2'd0) w_state_nxt = S_HOLD;
            S_HOLD:  if (w_accept) w_state_nxt = k_if.k_last ? S_FIN : S_ISSUE;
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // cur_addr only moves on entry to ISSUE, so it doubles as the held memory address.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_base     <= '0;
            r_num      <= '0;
            r_cur_addr <= '0;
            r_idx      <= '0;
            r_wait_cnt <= '0;
            r_addr_err <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base     <= base_addr;
                        r_num      <= num_kernels;
                        r_addr_err <= 1'b0;
                    end
                end
                S_CHECK: begin
                    if (r_num != 16'd0) begin
                        if (w_range_err) begin
                            r_addr_err <= 1'b1;
                        end else begin
                            r_cur_addr <= r_base;
                            r_idx      <= '0;
                        end
                    end
                end
                S_ISSUE: r_wait_cnt <= 2'(RD_LAT - 1);
                S_WAIT:  if (r_wait_cnt != 2'd0) r_wait_cnt <= r_wait_cnt - 2'd1;
                S_HOLD: begin
                    if (w_accept) begin
                        r_idx <= r_idx + 16'd1;
                        if (!k_if.k_last) r_cur_addr <= r_cur_addr + ADDR_W'(KWORDS);
                    end
                end
                default: ;
            endcase
        end
    end

    kernel_out_reg u_out (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_load),
        .i_clear  (w_start_acc),
        .i_data   (mem_data_out),
        .i_index  (r_idx),
        .i_last   (w_last),
        .o_accept (w_accept),
        .k_if     (k_if)
`ifdef FETCH_CHECKSUM_EN
        ,
        .o_csum   (csum)
`endif
    );

    assign mem_address      = r_cur_addr;
    assign mem_write_enable = 1'b0;
    assign busy             = (r_state != S_IDLE);
    assign done             = (r_state == S_FIN);
    assign addr_err         = r_addr_err;
endmodule
